// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command protocol.
// Holds the opcode constants (also used by the system controller), the
// request command and FSM state enums, and the frame/response lengths.
package uart_cmd_pkg;

    localparam logic [7:0] OPC_WR     = 8'hAA;
    localparam logic [7:0] OPC_RD     = 8'hBB;
    localparam logic [7:0] OPC_ALU    = 8'hCC;
    localparam logic [7:0] OPC_ALU_NO = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WR     = 2'd0,
        CMD_RD     = 2'd1,
        CMD_ALU    = 2'd2,
        CMD_ALU_NO = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_DONE
    } state_e;

    localparam logic [2:0] FRAME_LEN_WR     = 3'd3;
    localparam logic [2:0] FRAME_LEN_RD     = 3'd2;
    localparam logic [2:0] FRAME_LEN_ALU    = 3'd4;
    localparam logic [2:0] FRAME_LEN_ALU_NO = 3'd2;

    localparam logic [1:0] RSP_LEN_WR     = 2'd0;
    localparam logic [1:0] RSP_LEN_RD     = 2'd1;
    localparam logic [1:0] RSP_LEN_ALU    = 2'd2;
    localparam logic [1:0] RSP_LEN_ALU_NO = 2'd2;

    function automatic logic [2:0] frame_len(input cmd_e c);
        case (c)
            CMD_WR:  return FRAME_LEN_WR;
            CMD_RD:  return FRAME_LEN_RD;
            CMD_ALU: return FRAME_LEN_ALU;
            default: return FRAME_LEN_ALU_NO;
        endcase
    endfunction

    function automatic logic [1:0] rsp_len(input cmd_e c);
        case (c)
            CMD_WR:  return RSP_LEN_WR;
            CMD_RD:  return RSP_LEN_RD;
            CMD_ALU: return RSP_LEN_ALU;
            default: return RSP_LEN_ALU_NO;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_frame_sel.sv
// Combinational frame byte selector: given the request fields and a byte
// index, returns that byte of the frame, whether it is the last byte, and
// how many response bytes the command expects.
module uart_cmd_frame_sel
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  cmd_e                  i_cmd,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    input  logic [3:0]            i_fun,
    input  logic [1:0]            i_idx,
    output logic [DATA_WIDTH-1:0] o_byte,
    output logic                  o_last,
    output logic [1:0]            o_rsp_len
);

    logic [DATA_WIDTH-1:0] w_addr_ext;
    logic [DATA_WIDTH-1:0] w_fun_ext;

    assign w_addr_ext = DATA_WIDTH'(i_addr);
    assign w_fun_ext  = DATA_WIDTH'(i_fun);

    // Byte mux per command and index
    always_comb begin
        o_byte = '0;
        case (i_cmd)
            CMD_WR: begin
                case (i_idx)
                    2'd0:    o_byte = DATA_WIDTH'(OPC_WR);
                    2'd1:    o_byte = w_addr_ext;
                    default: o_byte = i_data;
                endcase
            end
            CMD_RD: begin
                o_byte = (i_idx == 2'd0) ? DATA_WIDTH'(OPC_RD) : w_addr_ext;
            end
            CMD_ALU: begin
                case (i_idx)
                    2'd0:    o_byte = DATA_WIDTH'(OPC_ALU);
                    2'd1:    o_byte = i_data;
                    2'd2:    o_byte = i_op_b;
                    default: o_byte = w_fun_ext;
                endcase
            end
            default: begin
                o_byte = (i_idx == 2'd0) ? DATA_WIDTH'(OPC_ALU_NO) : w_fun_ext;
            end
        endcase
    end

    assign o_last    = ({1'b0, i_idx} == (frame_len(i_cmd) - 3'd1));
    assign o_rsp_len = rsp_len(i_cmd);

endmodule

// File: rtl/uart_cmd_master.sv
// UART command master: serializes one request into an AA/BB/CC/DD frame
// toward UART TX and assembles up to two response bytes from UART RX into
// a 16-bit result.
// Optional feature: define UART_CMD_MASTER_TIMEOUT_EN to bound WAIT_RSP by
// RSP_TIMEOUT cycles (completion with o_rsp_err=1); otherwise it waits forever.
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 4,
    parameter int unsigned RSP_TIMEOUT = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_cmd,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    input  logic [DATA_WIDTH-1:0] i_req_op_b,
    input  logic [3:0]            i_req_fun,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [15:0]           o_rsp_data,
    output logic                  o_rsp_valid,
    output logic                  o_rsp_err,
    output logic                  o_busy
);

    state_e                r_state;
    cmd_e                  r_cmd;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_op_b;
    logic [3:0]            r_fun;
    logic [1:0]            r_idx;
    logic                  r_last;
    logic [1:0]            r_rsp_len;
    logic [1:0]            r_rx_cnt;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_tx_valid;
    logic [15:0]           r_rsp_data;
    logic                  r_rsp_valid;

    cmd_e                  w_sel_cmd;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [DATA_WIDTH-1:0] w_sel_op_b;
    logic [3:0]            w_sel_fun;
    logic [1:0]            w_sel_idx;
    logic [DATA_WIDTH-1:0] w_byte;
    logic                  w_last;
    logic [1:0]            w_rsp_len;

`ifdef UART_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(RSP_TIMEOUT + 1);
    logic [TMO_W-1:0]      r_tmo_cnt;
    logic                  r_rsp_err;
    assign o_rsp_err = r_rsp_err;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^RSP_TIMEOUT;
    assign o_rsp_err    = 1'b0;
`endif

    // The selector looks one byte ahead so TX_DATA can be registered: in IDLE
    // it sees the live request (byte 0), in SEND the byte after the current one.
    assign w_sel_cmd  = (r_state == ST_IDLE) ? cmd_e'(i_req_cmd) : r_cmd;
    assign w_sel_addr = (r_state == ST_IDLE) ? i_req_addr : r_addr;
    assign w_sel_data = (r_state == ST_IDLE) ? i_req_data : r_data;
    assign w_sel_op_b = (r_state == ST_IDLE) ? i_req_op_b : r_op_b;
    assign w_sel_fun  = (r_state == ST_IDLE) ? i_req_fun  : r_fun;
    assign w_sel_idx  = (r_state == ST_IDLE) ? 2'd0 : (r_idx + 2'd1);

    uart_cmd_frame_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_frame_sel (
        .i_cmd     (w_sel_cmd),
        .i_addr    (w_sel_addr),
        .i_data    (w_sel_data),
        .i_op_b    (w_sel_op_b),
        .i_fun     (w_sel_fun),
        .i_idx     (w_sel_idx),
        .o_byte    (w_byte),
        .o_last    (w_last),
        .o_rsp_len (w_rsp_len)
    );

    // Request/frame/response FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cmd       <= CMD_WR;
            r_addr      <= '0;
            r_data      <= '0;
            r_op_b      <= '0;
            r_fun       <= '0;
            r_idx       <= '0;
            r_last      <= 1'b0;
            r_rsp_len   <= '0;
            r_rx_cnt    <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_cmd      <= cmd_e'(i_req_cmd);
                        r_addr     <= i_req_addr;
                        r_data     <= i_req_data;
                        r_op_b     <= i_req_op_b;
                        r_fun      <= i_req_fun;
                        r_idx      <= '0;
                        r_tx_data  <= w_byte;
                        r_last     <= w_last;
                        r_rsp_len  <= w_rsp_len;
                        r_tx_valid <= 1'b1;
                        r_rsp_data <= '0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
                        r_rsp_err  <= 1'b0;
`endif
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (r_tx_valid && i_tx_ready) begin
                        if (r_last) begin
                            r_tx_valid <= 1'b0;
                            r_rx_cnt   <= '0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
                            r_tmo_cnt  <= '0;
`endif
                            if (r_rsp_len == 2'd0) begin
                                r_rsp_valid <= 1'b1;
                                r_state     <= ST_DONE;
                            end else begin
                                r_state <= ST_WAIT_RSP;
                            end
                        end else begin
                            r_idx     <= r_idx + 2'd1;
                            r_tx_data <= w_byte;
                            r_last    <= w_last;
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (i_rx_valid) begin
                        if (r_rx_cnt == 2'd0) begin
                            r_rsp_data[7:0] <= 8'(i_rx_data);
                        end else begin
                            r_rsp_data[15:8] <= 8'(i_rx_data);
                        end
                        r_rx_cnt <= r_rx_cnt + 2'd1;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                        if ((r_rx_cnt + 2'd1) == r_rsp_len) begin
                            r_rsp_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end
                    end
`ifdef UART_CMD_MASTER_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(RSP_TIMEOUT - 1)) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_tx_data   = r_tx_data;
    assign o_tx_valid  = r_tx_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_valid = r_rsp_valid;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Self-checking bench for uart_cmd_master: table vectors, hand-written
// corner sequences and randomized requests against a frame/response model.
module tb_uart_cmd_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_cmd;
    logic [3:0]  req_addr;
    logic [7:0]  req_data;
    logic [7:0]  req_op_b;
    logic [3:0]  req_fun;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_err;
    logic        busy;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    uart_cmd_master #(
        .DATA_WIDTH  (8),
        .ADDR_WIDTH  (4),
        .RSP_TIMEOUT (16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_cmd   (req_cmd),
        .i_req_addr  (req_addr),
        .i_req_data  (req_data),
        .i_req_op_b  (req_op_b),
        .i_req_fun   (req_fun),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rsp_data  (rsp_data),
        .o_rsp_valid (rsp_valid),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy)
    );

    typedef struct {
        logic [1:0]  cmd;
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [7:0]  op_b;
        logic [3:0]  fun;
        logic [7:0]  rx0;
        logic [7:0]  rx1;
        int          stall_idx;
        int          stall_n;
        logic [15:0] exp_rsp;
    } vec_t;

    typedef logic [7:0] byteq_t[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the byte stream a command puts on the wire
    function automatic byteq_t model_frame(input logic [1:0] cmd, input logic [3:0] addr,
                                           input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] fun);
        byteq_t q;
        case (cmd)
            2'd0: begin q.push_back(8'hAA); q.push_back({4'h0, addr}); q.push_back(a); end
            2'd1: begin q.push_back(8'hBB); q.push_back({4'h0, addr}); end
            2'd2: begin q.push_back(8'hCC); q.push_back(a); q.push_back(b); q.push_back({4'h0, fun}); end
            default: begin q.push_back(8'hDD); q.push_back({4'h0, fun}); end
        endcase
        return q;
    endfunction

    function automatic int model_nrsp(input logic [1:0] cmd);
        return (cmd == 2'd0) ? 0 : (cmd == 2'd1) ? 1 : 2;
    endfunction

    function automatic logic [15:0] model_rsp(input logic [1:0] cmd, input logic [7:0] rx0,
                                              input logic [7:0] rx1);
        int n = model_nrsp(cmd);
        if (n == 0) return 16'h0000;
        if (n == 1) return {8'h00, rx0};
        return {rx1, rx0};
    endfunction

    // One full request; entered and left at a negedge with the DUT idle
    task automatic do_req(input vec_t v, input bit stray, input int gap);
        byteq_t fr;
        int nr;
        fr = model_frame(v.cmd, v.addr, v.data, v.op_b, v.fun);
        nr = model_nrsp(v.cmd);
        chk("req_ready_idle", {31'd0, req_ready}, 1);
        req_valid = 1'b1;
        req_cmd   = v.cmd;
        req_addr  = v.addr;
        req_data  = v.data;
        req_op_b  = v.op_b;
        req_fun   = v.fun;
        tx_ready  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_data  = 8'($urandom);
        for (int k = 0; k < fr.size(); k++) begin
            chk("tx_valid", {31'd0, tx_valid}, 1);
            chk("tx_byte", {24'd0, tx_data}, {24'd0, fr[k]});
            chk("busy_send", {31'd0, busy}, 1);
            if (k == v.stall_idx) begin
                for (int s = 0; s < v.stall_n; s++) begin
                    tx_ready = 1'b0;
                    rx_valid = stray ? 1'($urandom) : 1'b0;
                    rx_data  = 8'($urandom);
                    @(negedge clk);
                    chk("tx_hold_valid", {31'd0, tx_valid}, 1);
                    chk("tx_hold_byte", {24'd0, tx_data}, {24'd0, fr[k]});
                end
            end
            tx_ready = 1'b1;
            rx_valid = stray ? 1'($urandom) : 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("tx_valid_end", {31'd0, tx_valid}, 0);
        if (nr != 0) begin
            for (int j = 0; j < nr; j++) begin
                for (int g = 0; g < gap; g++) begin
                    chk("rsp_early", {31'd0, rsp_valid}, 0);
                    @(negedge clk);
                end
                chk("rsp_early", {31'd0, rsp_valid}, 0);
                rx_valid = 1'b1;
                rx_data  = (j == 0) ? v.rx0 : v.rx1;
                @(negedge clk);
                rx_valid = 1'b0;
            end
        end
        chk("rsp_valid", {31'd0, rsp_valid}, 1);
        chk("rsp_data", {16'd0, rsp_data}, {16'd0, v.exp_rsp});
        chk("rsp_err", {31'd0, rsp_err}, 0);
        @(negedge clk);
        chk("rsp_pulse", {31'd0, rsp_valid}, 0);
        chk("busy_after", {31'd0, busy}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[4];
        vec_t v;

        rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_data = '0;
        req_op_b = '0; req_fun = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        tbl[0] = '{cmd:2'd0, addr:4'd5, data:8'h3C, op_b:8'h00, fun:4'd0, rx0:8'h00, rx1:8'h00,
                   stall_idx:-1, stall_n:0, exp_rsp:16'h0000};
        tbl[1] = '{cmd:2'd1, addr:4'd2, data:8'h00, op_b:8'h00, fun:4'd0, rx0:8'h7E, rx1:8'h00,
                   stall_idx:1, stall_n:3, exp_rsp:16'h007E};
        tbl[2] = '{cmd:2'd2, addr:4'd0, data:8'h10, op_b:8'h20, fun:4'd1, rx0:8'h34, rx1:8'h12,
                   stall_idx:-1, stall_n:0, exp_rsp:16'h1234};
        tbl[3] = '{cmd:2'd3, addr:4'd0, data:8'h00, op_b:8'h00, fun:4'd15, rx0:8'h55, rx1:8'h66,
                   stall_idx:0, stall_n:2, exp_rsp:16'h6655};
        for (int i = 0; i < 4; i++) do_req(tbl[i], 1'b0, i);

        // Stray RX strobes while the frame is still being sent
        v = '{cmd:2'd2, addr:4'd0, data:8'hA1, op_b:8'hB2, fun:4'd9, rx0:8'hC3, rx1:8'hD4,
              stall_idx:2, stall_n:2, exp_rsp:16'hD4C3};
        do_req(v, 1'b1, 0);

        // Reset in the middle of a CC frame
        req_valid = 1'b1; req_cmd = 2'd2; req_data = 8'h11; req_op_b = 8'h22; req_fun = 4'd5;
        tx_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_byte1", {24'd0, tx_data}, 32'h11);
        @(negedge clk);
        chk("mid_byte2", {24'd0, tx_data}, 32'h22);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_no_more_tx", {31'd0, tx_valid}, 0);
        v = '{cmd:2'd3, addr:4'd0, data:8'h00, op_b:8'h00, fun:4'd3, rx0:8'h9A, rx1:8'hBC,
              stall_idx:-1, stall_n:0, exp_rsp:16'hBC9A};
        do_req(v, 1'b0, 1);

`ifdef UART_CMD_MASTER_TIMEOUT_EN
        // One ALU byte then silence: error completion RSP_TIMEOUT cycles later
        begin
            int n;
            req_valid = 1'b1; req_cmd = 2'd3; req_fun = 4'd3; tx_ready = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            chk("tmo_byte0", {24'd0, tx_data}, 32'hDD);
            @(negedge clk);
            chk("tmo_byte1", {24'd0, tx_data}, 32'h03);
            @(negedge clk);
            rx_valid = 1'b1; rx_data = 8'h44;
            @(negedge clk);
            rx_valid = 1'b0;
            n = 0;
            while (!rsp_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("tmo_cycles", n, 16);
            chk("tmo_err", {31'd0, rsp_err}, 1);
            chk("tmo_data", {16'd0, rsp_data}, 0);
            @(negedge clk);
            chk("tmo_idle", {31'd0, busy}, 0);
        end
`else
        // Without the timeout, a long response gap must not end the wait
        v = '{cmd:2'd3, addr:4'd0, data:8'h00, op_b:8'h00, fun:4'd7, rx0:8'h01, rx1:8'h80,
              stall_idx:-1, stall_n:0, exp_rsp:16'h8001};
        do_req(v, 1'b0, 40);
`endif

        // Randomized requests against the model
        for (int r = 0; r < 40; r++) begin
            v.cmd       = 2'($urandom);
            v.addr      = 4'($urandom);
            v.data      = 8'($urandom);
            v.op_b      = 8'($urandom);
            v.fun       = 4'($urandom);
            v.rx0       = 8'($urandom);
            v.rx1       = 8'($urandom);
            v.stall_idx = int'($urandom_range(0, 4));
            v.stall_n   = int'($urandom_range(0, 3));
            v.exp_rsp   = model_rsp(v.cmd, v.rx0, v.rx1);
            do_req(v, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_master.md
# uart_cmd_master

Host-side initiator for the UART command protocol served by the system controller. Accepts one command request at a time and serializes it into the frame byte stream for the UART transmitter: 0xAA write, 0xBB read, 0xCC ALU-with-operands, 0xDD ALU-no-operands. Collects the response bytes from the UART receiver and returns them as a single 16-bit result. Sits between a test host or bus bridge and the UART TX/RX pair, inside the UART clock domain.

## Interface
- DATA_WIDTH, 8: UART byte width.
- ADDR_WIDTH, 4: register-file address width.
- RSP_TIMEOUT, 4096: response-wait limit in CLK cycles. Used only with the timeout feature.

- CLK  in  1  block clock.
- RST  in  1  reset; asynchronous and active-high.
- REQ_VALID  in  1  request offered.
- REQ_READY  out  1  request accepted when high together with REQ_VALID.
- REQ_CMD  in  2  command: 0 RF write, 1 RF read, 2 ALU with operands, 3 ALU without operands.
- REQ_ADDR  in  ADDR_WIDTH  register address (commands 0/1).
- REQ_DATA  in  DATA_WIDTH  write data (command 0) or operand A (command 2).
- REQ_OP_B  in  DATA_WIDTH  operand B (command 2).
- REQ_FUN  in  4  ALU function (commands 2/3).
- TX_DATA  out  DATA_WIDTH  byte toward UART TX.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  UART TX accepts the byte.
- RX_DATA  in  DATA_WIDTH  byte from UART RX.
- RX_VALID  in  1  one-cycle strobe with RX_DATA.
- RSP_DATA  out  16  response value.
- RSP_VALID  out  1  one-cycle completion strobe.
- RSP_ERR  out  1  qualifies RSP_VALID; high when the request timed out.
- BUSY  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SEND, WAIT_RSP, DONE.
- IDLE: REQ_READY=1. On REQ_VALID, all request fields are latched, the byte index is set to 0, and the state moves to SEND.
- Frames (byte 0 first):
  - cmd 0: AA, {0,addr}, data. 3 bytes, 0 response bytes.
  - cmd 1: BB, {0,addr}. 2 bytes, 1 response byte.
  - cmd 2: CC, A, B, {0,fun}. 4 bytes, 2 response bytes.
  - cmd 3: DD, {0,fun}. 2 bytes, 2 response bytes.
  - Address and fun are zero-extended to 8 bits.
- SEND: the byte index advances on TX_VALID && TX_READY. After the last byte is accepted:
  - 0 response bytes: go to DONE.
  - otherwise: go to WAIT_RSP.
- WAIT_RSP: each RX_VALID stores one byte. The first byte goes to RSP_DATA[7:0]; the second (ALU only) goes to [15:8]. Bytes not stored stay 0. After the last expected byte, go to DONE.
- DONE: RSP_VALID=1 for exactly one cycle, then go to IDLE.
- Write commands complete with RSP_DATA=0 and RSP_ERR=0.
- RX_VALID outside WAIT_RSP is ignored, including a strobe in the same cycle as the last TX handshake.
- RSP_DATA is cleared when a new request is accepted.

## Timing
- Reset values: TX_VALID=0, TX_DATA=0, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0, BUSY=0, state IDLE.
- REQ_READY is decoded from state, so it reads 1 during reset.
- Reset mid-frame abandons the frame immediately; no further TX bytes are sent.
- TX_DATA and TX_VALID are registered. Byte 0 appears the cycle after request acceptance.
- TX_DATA is held stable while TX_VALID && !TX_READY.
- With TX_READY held high, consecutive bytes are issued on consecutive cycles.
- RSP_VALID rises the cycle after the last RX byte, or after the last TX handshake for a write.
- Minimum back-to-back request spacing: the next request is accepted the cycle after RSP_VALID.

## Configuration
- Macro: UART_CMD_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RSP and is cleared on entry and on each RX_VALID.
  - On reaching RSP_TIMEOUT, the block goes to DONE with RSP_ERR=1 and RSP_DATA=0, even if one ALU byte had arrived.
- Undefined:
  - No counter; WAIT_RSP waits indefinitely.
  - RSP_ERR is tied 0.

## Structure
- Package uart_cmd_pkg holds:
  - opcode constants AA/BB/CC/DD;
  - the cmd_e enum for REQ_CMD;
  - the state enum;
  - frame-length and response-length constants per command.
  - The system controller shares the opcode constants.
- Sub-module uart_cmd_frame_sel: combinational. Takes latched request fields and byte index; outputs the byte value, a last-byte flag and the response length.

## Test plan
- Write: REQ_CMD=0, addr=5, data=0x3C, TX_READY=1 → TX bytes AA,05,3C on 3 consecutive cycles, then RSP_VALID with RSP_DATA=0x0000.
- Read with TX stall: REQ_CMD=1, addr=2, TX_READY low for 3 cycles on byte 1 → byte 02 held stable; RX 0x7E → RSP_DATA=0x007E.
- ALU: REQ_CMD=2, A=0x10, B=0x20, fun=1 → TX CC,10,20,01; RX 0x34 then 0x12 → RSP_DATA=0x1234, RSP_ERR=0.
- Stray RX: RX_VALID pulses during SEND → ignored; RSP_DATA still equals the correct response bytes.
- Reset mid-frame: RST asserted after byte 1 of a CC frame → TX_VALID=0 immediately, BUSY=0; a new DD,03 request then runs normally.
- Timeout (macro defined, RSP_TIMEOUT=16): REQ_CMD=3, one RX byte then silence → RSP_VALID with RSP_ERR=1 and RSP_DATA=0 16 cycles after that byte.
